bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//  Sequential, parametrised binary-to-BCD converter (shift-and-add-3, one bit per clock).
//  Produces every decimal digit of a WIDTH-bit input, not only the units digit.
//  Optional two's-complement input mode.
//  Ready/valid handshakes on both sides; sits between datapath results and the
//  7-segment display drivers.
// PARAMETERS
//  WIDTH   8  binary input width; legal range 2..32
//  DIGITS  3  number of BCD output digits; 4 bits per digit
//  SIGNED  0  0: unsigned input; 1: two's-complement input, output is sign + magnitude
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous reset, active high
//  in_valid   in   1          bin_in is valid
//  in_ready   out  1          converter can accept a new value
//  bin_in     in   WIDTH      binary operand
//  out_valid  out  1          bcd_out, sign_out and ovf are valid
//  out_ready  in   1          consumer accepts the result
//  bcd_out    out  4*DIGITS   packed BCD; digit k occupies bits [4k+3:4k]; digit 0 is the units digit
//  sign_out   out  1          1 = negative input; only when SIGNED=1, else tied 0
//  ovf        out  1          1 = value needs more than DIGITS digits
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - state IDLE; bcd_out=0, sign_out=0, ovf=0, out_valid=0.
//   - in_ready=0 while rst is high.
//   - Reset has priority over everything, including a conversion in progress
//     (the partial result is discarded).
//  Handshakes:
//   - in_ready = (state==IDLE) && !rst.
//   - Accept occurs on an edge with in_valid && in_ready.
//   - Results transfer on an edge with out_valid && out_ready.
//  FSM:
//   - IDLE -> SHIFT on accept.
//      - Latch the operand. When SIGNED=1 and the MSB is 1, latch its magnitude
//        (negate into WIDTH+1 bits) and set sign_out.
//      - Clear the BCD accumulator, ovf and cnt.
//   - SHIFT, one step per cycle, in this order:
//      - Every digit >= 5 gets +3 (all digits in parallel).
//      - The accumulator shifts left 1, taking in the operand MSB; the operand shifts left 1.
//      - A 1 leaving the top digit's bit 3 sets ovf (sticky until the next accept).
//      - After the last step -> DONE.
//      - Number of steps: WIDTH when SIGNED=0, WIDTH+1 when SIGNED=1, so -2^(WIDTH-1) converts correctly.
//   - DONE: out_valid=1.
//      - bcd_out, sign_out and ovf stay stable until out_ready.
//      - DONE -> IDLE on the transfer edge.
//  Latency and throughput:
//   - out_valid rises N cycles after the accept edge (N = step count).
//   - Throughput: one result every N+2 cycles with out_ready held high.
//  Busy behaviour: in_valid in SHIFT or DONE is ignored; nothing is queued.
//   The producer must hold bin_in until it is accepted.
//  Overflow: when ovf=1, bcd_out holds the low DIGITS decimal digits (value mod 10^DIGITS).
//  Counter: cnt is $clog2(WIDTH+2) bits wide; it never wraps within a conversion.
//  Elaboration check: a $error fires when 4*DIGITS < WIDTH, or when
//   WIDTH is outside 2..32.
// STRUCTURE
//  Package bin2bcd_pkg:
//   - state encoding localparams ST_IDLE, ST_SHIFT, ST_DONE;
//   - function digits_needed(width), used by benches to choose DIGITS.
//  Sub-module bcd_digit_step (combinational; one instance per digit via generate):
//   - inputs: 4-bit digit, shift-in bit;
//   - outputs: corrected+shifted 4-bit digit, shift-out bit.
//   - The shift-out of digit k feeds the shift-in of digit k+1; the top digit's shift-out drives ovf.
//  The top level holds the FSM, operand register, counter and output registers.
// TESTING
//  - W8/D3: bin_in=255 -> bcd_out=12'h255, ovf=0; out_valid exactly 8 cycles after accept.
//  - W8/D3: 0, 9, 10, 99, 100 back-to-back, out_ready=1 -> 000, 009, 010, 099, 100,
//    one result every 10 cycles.
//  - W8/D3/SIGNED=1: 8'h80 -> sign_out=1, bcd 128; 8'hFF -> sign 1, bcd 001;
//    8'h7F -> sign 0, bcd 127.
//  - W8/D2: bin_in=200 -> ovf=1, bcd_out=8'h00; a following input of 42 -> ovf=0, bcd_out=8'h42.
//  - Backpressure: hold out_ready=0 for 6 cycles after out_valid; pulse in_valid mid-DONE
//    -> result stable, in_ready=0, pulsed input not converted.
//  - rst at the 4th SHIFT cycle of 16'd65535 (W16/D5) -> IDLE next cycle with outputs 0;
//    a fresh 65535 -> 20'h65535 after 16 cycles.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM state
// encoding and a helper that sizes the BCD digit count for a given width.
package bin2bcd_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_t;

  // Smallest d such that 10^d > 2^width - 1.
  function automatic int digits_needed(input int width);
    logic [63:0] lim;
    logic [63:0] p;
    int          d;
    lim = 64'd1 << width;
    p   = 64'd10;
    d   = 1;
    for (int i = 0; i < 20; i++) begin
      if (p < lim) begin
        p = p * 64'd10;
        d++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of a shift-and-add-3 step: correct the digit if it is 5 or
// more, then shift it left one place, passing its top bit to the next digit.
module bcd_digit_step (
  input  logic [3:0] digit,
  input  logic       shift_in,
  output logic [3:0] digit_next,
  output logic       shift_out
);

  logic [3:0] adj;

  always_comb begin
    adj = digit;
    if (digit >= 4'd5) adj = digit + 4'd3;
  end

  assign shift_out  = adj[3];
  assign digit_next = {adj[2:0], shift_in};

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one operand bit per clock, with an
// optional two's-complement input that is reported as sign plus magnitude.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    bin_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                sign_out,
  output logic                ovf
);

  // A signed operand gets one extra bit so that -2^(WIDTH-1) has a magnitude.
  localparam int STEPS = WIDTH + ((SIGNED != 0) ? 1 : 0);
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("bin2bcd_seq: WIDTH=%0d is outside 2..32", WIDTH);
  end
  if (4 * DIGITS < WIDTH) begin : g_bad_digits
    $error("bin2bcd_seq: 4*DIGITS=%0d is smaller than WIDTH=%0d", 4 * DIGITS, WIDTH);
  end

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [STEPS-1:0]      operand;

  logic                  neg;
  logic signed [WIDTH:0] sext;
  logic signed [WIDTH:0] negated;
  logic [STEPS-1:0]      magnitude;

  logic [DIGITS:0]       chain;
  logic [4*DIGITS-1:0]   bcd_step;

  assign in_ready = (state == S_IDLE) && !rst;

  // Operand capture: sign detection and magnitude
  assign neg     = (SIGNED != 0) && bin_in[WIDTH-1];
  assign sext    = $signed({bin_in[WIDTH-1], bin_in});
  assign negated = -sext;

  always_comb begin
    magnitude = STEPS'(bin_in);
    if (neg) magnitude = STEPS'($unsigned(negated));
  end

  // Digit chain: operand MSB enters the units digit, top digit carry flags overflow
  assign chain[0] = operand[STEPS-1];

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_step u_step (
      .digit      (bcd_out[4*k +: 4]),
      .shift_in   (chain[k]),
      .digit_next (bcd_step[4*k +: 4]),
      .shift_out  (chain[k+1])
    );
  end

  // FSM, counter, operand and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bcd_out   <= '0;
      sign_out  <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            operand  <= magnitude;
            sign_out <= neg;
            bcd_out  <= '0;
            ovf      <= 1'b0;
            cnt      <= '0;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd_out <= bcd_step;
          operand <= {operand[STEPS-2:0], 1'b0};
          if (chain[DIGITS]) ovf <= 1'b1;
          if (cnt == LAST) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: four configurations side by side, each checked every
// cycle against an arithmetic model of the conversion and handshake timing.
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  localparam int CW[4] = '{8, 8, 8, 16};
  localparam int CD[4] = '{3, 3, 2, 5};
  localparam int CS[4] = '{0, 1, 0, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  iv_v = '0;
  logic [3:0]  ordy_v = '1;
  logic [31:0] bin_a[4];
  logic [3:0]  ird_v, ov_v, sg_v, of_v;
  logic [11:0] bcd0, bcd1;
  logic [7:0]  bcd2;
  logic [19:0] bcd3;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  bit [3:0]    pending = '0;
  bit [3:0]    post_rst = '0;
  int          acc_cyc[4];
  logic [31:0] acc_val[4];

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(iv_v[0]), .in_ready(ird_v[0]), .bin_in(bin_a[0][7:0]),
    .out_valid(ov_v[0]), .out_ready(ordy_v[0]), .bcd_out(bcd0), .sign_out(sg_v[0]), .ovf(of_v[0]));
  bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv_v[1]), .in_ready(ird_v[1]), .bin_in(bin_a[1][7:0]),
    .out_valid(ov_v[1]), .out_ready(ordy_v[1]), .bcd_out(bcd1), .sign_out(sg_v[1]), .ovf(of_v[1]));
  bin2bcd_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(iv_v[2]), .in_ready(ird_v[2]), .bin_in(bin_a[2][7:0]),
    .out_valid(ov_v[2]), .out_ready(ordy_v[2]), .bcd_out(bcd2), .sign_out(sg_v[2]), .ovf(of_v[2]));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(iv_v[3]), .in_ready(ird_v[3]), .bin_in(bin_a[3][15:0]),
    .out_valid(ov_v[3]), .out_ready(ordy_v[3]), .bcd_out(bcd3), .sign_out(sg_v[3]), .ovf(of_v[3]));

  function automatic logic [19:0] bcd_of(input int i);
    case (i)
      0:       return 20'(bcd0);
      1:       return 20'(bcd1);
      2:       return 20'(bcd2);
      default: return bcd3;
    endcase
  endfunction

  function automatic void chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at cycle %0d: got %0h, expected %0h", nm, i, cyc, got, exp);
    end
  endfunction

  // Decimal conversion from plain arithmetic: magnitude, mod 10^d, digit by digit.
  function automatic void model(input int w, input int d, input int s, input logic [31:0] x,
                                output logic [19:0] b, output logic sg, output logic ov);
    logic [63:0] v;
    logic [63:0] m;
    v  = {32'd0, x} & ((64'd1 << w) - 64'd1);
    sg = 1'b0;
    if (s != 0 && v[w-1]) begin
      v  = (64'd1 << w) - v;
      sg = 1'b1;
    end
    m = 64'd1;
    for (int k = 0; k < d; k++) m = m * 64'd10;
    ov = (v >= m);
    v  = v % m;
    b  = '0;
    for (int k = 0; k < d; k++) begin
      b[4*k +: 4] = 4'(v % 64'd10);
      v = v / 64'd10;
    end
  endfunction

  // Transaction tracker: accepts, transfers and resets seen at each edge.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        pending[i]  <= 1'b0;
        post_rst[i] <= 1'b1;
      end else if (iv_v[i] && ird_v[i]) begin
        pending[i]  <= 1'b1;
        post_rst[i] <= 1'b0;
        acc_cyc[i]  <= cyc;
        acc_val[i]  <= bin_in_masked(i);
      end else if (ov_v[i] && ordy_v[i]) begin
        pending[i]  <= 1'b0;
      end
    end
    cyc <= cyc + 1;
  end

  function automatic logic [31:0] bin_in_masked(input int i);
    return (CW[i] == 32) ? bin_a[i] : (bin_a[i] & ((32'd1 << CW[i]) - 32'd1));
  endfunction

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    logic [19:0] eb;
    logic        es, eo;
    logic        ev;
    for (int i = 0; i < 4; i++) begin
      ev = pending[i] && ((cyc - acc_cyc[i]) > (CW[i] + CS[i]));
      chk("out_valid", i, 32'(ov_v[i]), 32'(ev));
      chk("in_ready", i, 32'(ird_v[i]), 32'(!pending[i] && !rst));
      if (ev) begin
        model(CW[i], CD[i], CS[i], acc_val[i], eb, es, eo);
        chk("bcd_out", i, 32'(bcd_of(i)), 32'(eb));
        chk("sign_out", i, 32'(sg_v[i]), 32'(es));
        chk("ovf", i, 32'(of_v[i]), 32'(eo));
      end
      if (post_rst[i] && !pending[i]) begin
        chk("rst_bcd", i, 32'(bcd_of(i)), 32'd0);
        chk("rst_flags", i, 32'({sg_v[i], of_v[i]}), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [31:0] x, output int a);
    int t;
    t = 0;
    a = 0;
    bin_a[i] = x;
    iv_v[i]  = 1'b1;
    while (!ird_v[i] && t < 200) begin
      tick();
      t++;
    end
    chk("accept_timeout", i, 32'(ird_v[i]), 32'd1);
    a = cyc;
    tick();
    iv_v[i] = 1'b0;
  endtask

  task automatic drain(input int i, input int hold, output logic [19:0] b, output logic s, output logic o);
    int t;
    t = 0;
    ordy_v[i] = 1'b0;
    while (!ov_v[i] && t < 200) begin
      tick();
      t++;
    end
    chk("result_timeout", i, 32'(ov_v[i]), 32'd1);
    repeat (hold) tick();
    b = bcd_of(i);
    s = sg_v[i];
    o = of_v[i];
    ordy_v[i] = 1'b1;
    tick();
  endtask

  initial begin
    logic [19:0] b;
    logic        s, o;
    int          a;
    int          acc[5];
    logic [31:0] tp[5];

    for (int i = 0; i < 4; i++) bin_a[i] = '0;
    tp = '{32'd0, 32'd9, 32'd10, 32'd99, 32'd100};

    // Pin the model and sizing helper with hand-computed values.
    model(8, 3, 0, 32'd255, b, s, o);
    chk("model_255", 0, 32'({b, s, o}), 32'({20'h00255, 1'b0, 1'b0}));
    model(8, 3, 1, 32'h80, b, s, o);
    chk("model_m128", 1, 32'({b, s, o}), 32'({20'h00128, 1'b1, 1'b0}));
    model(8, 2, 0, 32'd200, b, s, o);
    chk("model_200_d2", 2, 32'({b, s, o}), 32'({20'h00000, 1'b0, 1'b1}));
    model(16, 5, 0, 32'd65535, b, s, o);
    chk("model_65535", 3, 32'({b, s, o}), 32'({20'h65535, 1'b0, 1'b0}));
    chk("digits_needed_8", 0, 32'(digits_needed(8)), 32'd3);
    chk("digits_needed_16", 0, 32'(digits_needed(16)), 32'd5);
    chk("digits_needed_32", 0, 32'(digits_needed(32)), 32'd10);

    repeat (3) tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("reset_in_ready", i, 32'(ird_v[i]), 32'd1);
      chk("reset_outputs", i, 32'({bcd_of(i), ov_v[i], sg_v[i], of_v[i]}), 32'd0);
    end

    // Full-scale unsigned value.
    send(0, 32'd255, a);
    drain(0, 0, b, s, o);
    chk("w8_255", 0, 32'({b, o}), 32'({20'h00255, 1'b0}));

    // Back-to-back throughput with out_ready held high.
    ordy_v[0] = 1'b1;
    for (int k = 0; k < 5; k++) send(0, tp[k], acc[k]);
    for (int k = 1; k < 5; k++) chk("throughput", 0, 32'(acc[k] - acc[k-1]), 32'd10);
    repeat (12) tick();

    // Signed extremes.
    send(1, 32'h80, a);
    drain(1, 1, b, s, o);
    chk("s_m128", 1, 32'({b, s, o}), 32'({20'h00128, 1'b1, 1'b0}));
    send(1, 32'hFF, a);
    drain(1, 0, b, s, o);
    chk("s_m1", 1, 32'({b, s, o}), 32'({20'h00001, 1'b1, 1'b0}));
    send(1, 32'h7F, a);
    drain(1, 2, b, s, o);
    chk("s_127", 1, 32'({b, s, o}), 32'({20'h00127, 1'b0, 1'b0}));

    // Overflow with two digits, then cleared by the next conversion.
    send(2, 32'd200, a);
    drain(2, 0, b, s, o);
    chk("d2_200", 2, 32'({b, o}), 32'({20'h00000, 1'b1}));
    send(2, 32'd42, a);
    drain(2, 0, b, s, o);
    chk("d2_42", 2, 32'({b, o}), 32'({20'h00042, 1'b0}));

    // Backpressure with an ignored input pulse while the result is held.
    ordy_v[0] = 1'b0;
    send(0, 32'd77, a);
    a = 0;
    while (!ov_v[0] && a < 50) begin
      tick();
      a++;
    end
    repeat (2) tick();
    bin_a[0] = 32'd5;
    iv_v[0]  = 1'b1;
    chk("busy_in_ready", 0, 32'(ird_v[0]), 32'd0);
    tick();
    iv_v[0] = 1'b0;
    repeat (3) tick();
    chk("held_result", 0, 32'({bcd_of(0), ov_v[0]}), 32'({20'h00077, 1'b1}));
    ordy_v[0] = 1'b1;
    tick();
    chk("after_transfer", 0, 32'({ov_v[0], ird_v[0]}), 32'({1'b0, 1'b1}));
    repeat (12) tick();
    chk("pulse_dropped", 0, 32'(ov_v[0]), 32'd0);

    // Reset in the middle of a 16-bit conversion, then a clean rerun.
    send(3, 32'd65535, a);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_idle", 3, 32'({ird_v[3], ov_v[3]}), 32'({1'b1, 1'b0}));
    chk("midrst_bcd", 3, 32'(bcd_of(3)), 32'd0);
    send(3, 32'd65535, a);
    drain(3, 0, b, s, o);
    chk("w16_65535", 3, 32'({b, o}), 32'({20'h65535, 1'b0}));

    // Randomized operands with random backpressure on every configuration.
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < 25; n++) begin
        send(i, $urandom, a);
        drain(i, int'($urandom_range(0, 3)), b, s, o);
      end
    end

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
